// File: rtl/alu_control_seq_if.sv
// Issue/handshake bundle between the pipeline control and alu_control_seq.
// master = pipeline/decoder side, slave = alu_control_seq.
`timescale 1ns/1ps

interface alu_control_seq_if;
    logic       issue_valid;
    logic [1:0] alu_op;
    logic [5:0] funct;
    logic       flush;
    logic       ready;
    logic [3:0] alu_sel;
    logic       op_valid;
    logic       busy;
    logic       done;
    logic       illegal;

    modport master (
        output issue_valid, alu_op, funct, flush,
        input  ready, alu_sel, op_valid, busy, done, illegal
    );

    modport slave (
        input  issue_valid, alu_op, funct, flush,
        output ready, alu_sel, op_valid, busy, done, illegal
    );
endinterface

// File: rtl/alu_control_seq.sv
// ALU control decoder with a multi-cycle MUL/DIV sequencer, busy/ready
// handshake, flush and illegal-funct reporting.
`timescale 1ns/1ps

module alu_control_seq #(
    parameter bit          ENABLE_MULDIV = 1'b1,
    parameter int unsigned MUL_LAT       = 4,
    parameter int unsigned DIV_LAT       = 8
) (
    input  logic              clk,
    input  logic              rst,
    alu_control_seq_if.slave  bus
);

    typedef enum logic [2:0] {S_IDLE, S_SINGLE, S_MULTI, S_DONE, S_ILL} state_t;
    typedef enum logic [1:0] {K_SINGLE, K_MULTI, K_ILLEGAL} kind_t;
    typedef enum logic [3:0] {
        SEL_ADD = 4'd0, SEL_SUB = 4'd1, SEL_AND = 4'd2, SEL_OR = 4'd3,
        SEL_XOR = 4'd4, SEL_NOR = 4'd5, SEL_SLT = 4'd6, SEL_SLL = 4'd7,
        SEL_SRL = 4'd8, SEL_SRA = 4'd9, SEL_PASSB = 4'd10, SEL_MUL = 4'd11,
        SEL_DIV = 4'd12
    } sel_t;

    state_t     state;
    logic [3:0] cnt;
    logic [3:0] sel_q;
    logic       op_valid_q;
    logic       busy_q;
    logic       done_q;
    logic       illegal_q;

    sel_t       dec_sel;
    kind_t      dec_kind;
    logic [3:0] dec_cnt;
    logic       accept;

    assign bus.ready    = ~busy_q;
    assign bus.alu_sel  = sel_q;
    assign bus.op_valid = op_valid_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.illegal  = illegal_q;

    assign accept = bus.issue_valid & ~busy_q & ~bus.flush;

    always_comb begin
        dec_sel  = SEL_ADD;
        dec_kind = K_SINGLE;
        dec_cnt  = '0;
        case (bus.alu_op)
            2'b00: dec_sel = SEL_ADD;
            2'b01: dec_sel = SEL_SUB;
            2'b11: dec_sel = SEL_PASSB;
            default: begin
                case (bus.funct)
                    6'h20, 6'h21: dec_sel = SEL_ADD;
                    6'h22, 6'h23: dec_sel = SEL_SUB;
                    6'h24:        dec_sel = SEL_AND;
                    6'h25:        dec_sel = SEL_OR;
                    6'h26:        dec_sel = SEL_XOR;
                    6'h27:        dec_sel = SEL_NOR;
                    6'h2A:        dec_sel = SEL_SLT;
                    6'h00:        dec_sel = SEL_SLL;
                    6'h02:        dec_sel = SEL_SRL;
                    6'h03:        dec_sel = SEL_SRA;
                    6'h18: begin
                        dec_sel  = SEL_MUL;
                        dec_kind = ENABLE_MULDIV ? K_MULTI : K_ILLEGAL;
                        dec_cnt  = 4'(MUL_LAT - 2);
                    end
                    6'h1A: begin
                        dec_sel  = SEL_DIV;
                        dec_kind = ENABLE_MULDIV ? K_MULTI : K_ILLEGAL;
                        dec_cnt  = 4'(DIV_LAT - 2);
                    end
                    default:      dec_kind = K_ILLEGAL;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            sel_q      <= '0;
            op_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            illegal_q  <= 1'b0;
        end else if (bus.flush) begin
            state      <= S_IDLE;
            cnt        <= '0;
            op_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            illegal_q  <= 1'b0;
        end else if (accept) begin
            // ready is low throughout MULTI, so an accept never interrupts it
            case (dec_kind)
                K_SINGLE: begin
                    state      <= S_SINGLE;
                    sel_q      <= dec_sel;
                    op_valid_q <= 1'b1;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b1;
                    illegal_q  <= 1'b0;
                end
                K_MULTI: begin
                    state      <= S_MULTI;
                    cnt        <= dec_cnt;
                    sel_q      <= dec_sel;
                    op_valid_q <= 1'b1;
                    busy_q     <= 1'b1;
                    done_q     <= 1'b0;
                    illegal_q  <= 1'b0;
                end
                default: begin
                    state      <= S_ILL;
                    op_valid_q <= 1'b0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                    illegal_q  <= 1'b1;
                end
            endcase
        end else if (state == S_MULTI) begin
            if (cnt == '0) begin
                state  <= S_DONE;
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end else begin
                cnt <= cnt - 4'd1;
            end
        end else begin
            state      <= S_IDLE;
            op_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            illegal_q  <= 1'b0;
        end
    end

endmodule
